// File: rtl/decode_sequencer_pkg.sv
// Shared types for the decode sequencer: fetch packet layout, decoder NOP and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_sequencer_pkg;

  // Canonical RV32I NOP (addi x0, x0, 0); shown to the decoder whenever the queue is empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } seq_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Circular buffer of fetch packets with head/tail pointers one bit wider than the index.
// Latency: a push is visible at the head on the following cycle when the buffer was empty.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
// Ports: push/push_pkt write at tail, pop advances head, clear resets both pointers
//        (wins over push/pop); head_pkt, full, empty, occupancy describe current state.
module instr_fifo
  import decode_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_pkt_t                   push_pkt,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_pkt_t                   head_pkt,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(DEPTH + 1);

  fetch_pkt_t    mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] ptr_diff;

  // Storage is deliberately not reset: only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail_ptr[AW-1:0]] <= push_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
    end
  end

  // Extra pointer MSB distinguishes full (lap ahead) from empty (same lap).
  assign full      = (tail_ptr[AW] != head_ptr[AW]) && (tail_ptr[AW-1:0] == head_ptr[AW-1:0]);
  assign empty     = (tail_ptr == head_ptr);
  assign ptr_diff  = tail_ptr - head_ptr;
  assign occupancy = OW'(ptr_diff);
  assign head_pkt  = mem[head_ptr[AW-1:0]];

endmodule

// File: rtl/decode_sequencer.sv
// Instruction buffer between fetch and issue; shows head to an external decoder, dispatches legal heads, traps on illegal.
// Latency: packet accepted in cycle N can dispatch in N+1; head->dec_instr->dec_legal->disp_valid is combinational.
// Backpressure: fetch_ready drops when full, flushing or trapped; head is held while disp_valid && !disp_ready.
// Ports: fetch_* (valid/ready input), dec_instr/dec_legal (decoder loop), disp_* (valid/ready output),
//        flush (empties queue, clears trap), illegal_trap/illegal_pc (trap status), occupancy (live entries).
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [31:0]                  fetch_instr,
  input  logic [31:0]                  fetch_pc,
  output logic [31:0]                  dec_instr,
  input  logic                         dec_legal,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [31:0]                  disp_pc,
  output logic [31:0]                  disp_instr,
  input  logic                         flush,
  output logic                         illegal_trap,
  output logic [31:0]                  illegal_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic [31:0] illegal_pc_q;

  fetch_pkt_t head_pkt;
  fetch_pkt_t push_pkt;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       trap_detect;

  assign push_pkt.pc    = fetch_pc;
  assign push_pkt.instr = fetch_instr;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pkt  (push_pkt),
    .pop       (pop),
    .clear     (flush),
    .head_pkt  (head_pkt),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // Illegal head seen while running; flush in the same cycle cancels it.
  assign trap_detect = (state_q == RUN) && !empty && !dec_legal && !flush;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush always returns to RUN, and is the only exit from TRAP.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else if (trap_detect) begin
      state_d = TRAP;
    end
  end

  // Output logic
  always_comb begin
    fetch_ready  = 1'b0;
    disp_valid   = 1'b0;
    illegal_trap = 1'b0;
    unique case (state_q)
      RUN: begin
        fetch_ready = !full && !flush;
        disp_valid  = !empty && dec_legal && !flush;
      end
      TRAP: begin
        illegal_trap = 1'b1;
      end
      default: ;
    endcase
  end

  assign push = fetch_valid && fetch_ready;
  assign pop  = disp_valid && disp_ready;

  // Offending PC is captured on detection and held until flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_pc_q <= '0;
    end else if (flush) begin
      illegal_pc_q <= '0;
    end else if (trap_detect) begin
      illegal_pc_q <= head_pkt.pc;
    end
  end

  assign illegal_pc = illegal_pc_q;

  // Head is masked while empty so stale storage never leaks onto the outputs.
  assign dec_instr  = empty ? NOP_INSTR : head_pkt.instr;
  assign disp_pc    = empty ? 32'h0 : head_pkt.pc;
  assign disp_instr = empty ? 32'h0 : head_pkt.instr;

endmodule
